// File: rtl/typedefs.sv
// Shared types for the instruction-sequencing controller.
//   opcode_t : 3-bit instruction opcode
//   state_t  : 8-phase controller state, encoded 0..7 in sequence order
package typedefs;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } state_t;

endpackage

// File: rtl/controller.sv
// Instruction-sequencing controller for a simple accumulator CPU.
// Steps through a fixed 8-phase loop, one phase per clock, and decodes the
// current phase together with opcode/zero into datapath control strobes.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   reset   in   asynchronous active-low reset (forces INST_ADDR)
//   opcode  in   current instruction opcode (typedefs::opcode_t)
//   zero    in   accumulator-is-zero flag
//   mem_rd  out  memory read enable
//   load_ir out  instruction register load
//   halt    out  halt request
//   inc_pc  out  program counter increment
//   load_ac out  accumulator load
//   load_pc out  program counter load
//   mem_wr  out  memory write enable
module controller
   import typedefs::*;
(
   input  logic    clk,
   input  logic    reset,
   input  opcode_t opcode,
   input  logic    zero,
   output logic    mem_rd,
   output logic    load_ir,
   output logic    halt,
   output logic    inc_pc,
   output logic    load_ac,
   output logic    load_pc,
   output logic    mem_wr
);

   state_t state;
   logic   w_aluop;

   // Phase sequence never depends on inputs; halt is only advisory.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= INST_ADDR;
      end else begin
         case (state)
            INST_ADDR:  state <= INST_FETCH;
            INST_FETCH: state <= INST_LOAD;
            INST_LOAD:  state <= IDLE;
            IDLE:       state <= OP_ADDR;
            OP_ADDR:    state <= OP_FETCH;
            OP_FETCH:   state <= ALU_OP;
            ALU_OP:     state <= STORE;
            STORE:      state <= INST_ADDR;
            default:    state <= INST_ADDR;
         endcase
      end
   end

   // Opcodes that read an operand from memory into the accumulator.
   assign w_aluop = (opcode == ADD) || (opcode == AND) ||
                    (opcode == XOR) || (opcode == LDA);

   // Outputs are combinational so opcode/zero changes show in the same cycle.
   always_comb begin
      mem_rd  = 1'b0;
      load_ir = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      mem_wr  = 1'b0;
      case (state)
         INST_ADDR: ;
         INST_FETCH: begin
            mem_rd = 1'b1;
         end
         INST_LOAD, IDLE: begin
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (opcode == HLT);
         end
         OP_FETCH: begin
            mem_rd = w_aluop;
         end
         ALU_OP: begin
            mem_rd  = w_aluop;
            load_ac = w_aluop;
            inc_pc  = (opcode == SKZ) && zero;
            load_pc = (opcode == JMP);
         end
         STORE: begin
            mem_rd  = w_aluop;
            load_ac = w_aluop;
            inc_pc  = (opcode == JMP);
            load_pc = (opcode == JMP);
            mem_wr  = (opcode == STO);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_controller.sv
module tb_controller;
   import typedefs::*;

   logic    clk = 1'b0;
   logic    reset;
   opcode_t opcode;
   logic    zero;
   logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

   int vectors = 0;
   int miscompares = 0;

   controller dut (
      .clk     (clk),
      .reset   (reset),
      .opcode  (opcode),
      .zero    (zero),
      .mem_rd  (mem_rd),
      .load_ir (load_ir),
      .halt    (halt),
      .inc_pc  (inc_pc),
      .load_ac (load_ac),
      .load_pc (load_pc),
      .mem_wr  (mem_wr)
   );

   always #5 clk = ~clk;

   typedef struct {
      opcode_t              op;
      logic                 z;
      logic [0:7][6:0]      exp;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [6:0] got_vec();
      return {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
   endfunction

   // Reference: phase number since reset (0..7) plus the rule table per phase.
   function automatic logic [6:0] model(int phase, opcode_t op, logic z);
      logic alu;
      alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
      case (phase)
         1:       return 7'b1000000;
         2, 3:    return 7'b1100000;
         4:       return {2'b00, (op == HLT), 1'b1, 3'b000};
         5:       return {alu, 6'b0};
         6:       return {alu, 2'b00, (op == SKZ) && z, alu, (op == JMP), 1'b0};
         7:       return {alu, 2'b00, (op == JMP), alu, (op == JMP), (op == STO)};
         default: return 7'b0;
      endcase
   endfunction

   task automatic check(string name, logic [6:0] exp, int phase);
      vectors++;
      if (got_vec() !== exp || dut.state !== state_t'(phase[2:0])) begin
         miscompares++;
         $display("FAIL %s: got outputs=%b state=%0d, expected outputs=%b state=%0d",
                  name, got_vec(), dut.state, exp, phase);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_hold", 7'b0, 0);
      #1 reset = 1'b1;
   endtask

   int phase;

   initial begin
      reset  = 1'b0;
      opcode = HLT;
      zero   = 1'b0;

      tbl[0] = '{HLT, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0011000, 7'b0000000, 7'b0000000, 7'b0000000}};
      tbl[1] = '{ADD, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100}};
      tbl[2] = '{AND, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100}};
      tbl[3] = '{XOR, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100}};
      tbl[4] = '{LDA, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100}};
      tbl[5] = '{SKZ, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000}};
      tbl[6] = '{SKZ, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000}};
      tbl[7] = '{STO, 1'b0, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b0000000, 7'b0000000, 7'b0000001}};
      tbl[8] = '{JMP, 1'b1, {7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000,
                             7'b0001000, 7'b0000000, 7'b0000010, 7'b0001010}};

      // Table vectors: reset, release, then one full loop plus the wrap.
      for (int t = 0; t < 9; t++) begin
         opcode = tbl[t].op;
         zero   = tbl[t].z;
         do_reset();
         check($sformatf("tbl%0d_p0", t), tbl[t].exp[0], 0);
         for (int p = 1; p < 8; p++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_p%0d", t, p), tbl[t].exp[p], p);
         end
         @(negedge clk);
         check($sformatf("tbl%0d_wrap", t), tbl[t].exp[0], 0);
      end

      // Async reset in ALU_OP: outputs clear with no clock edge.
      opcode = ADD;
      zero   = 1'b0;
      do_reset();
      for (int p = 1; p < 7; p++) @(negedge clk);
      check("alu_before_rst", 7'b1000100, 6);
      #2 reset = 1'b0;
      #1 check("alu_async_rst", 7'b0000000, 0);
      @(negedge clk);
      check("rst_held", 7'b0000000, 0);
      #1 reset = 1'b1;
      check("restart_p0", 7'b0000000, 0);
      @(negedge clk);
      check("restart_p1", 7'b1000000, 1);

      // Randomized run against the phase model, with random async resets.
      do_reset();
      phase = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         phase = reset ? (phase + 1) % 8 : 0;
         #1;
         opcode = opcode_t'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         if (reset && $urandom_range(0, 39) == 0) begin
            reset = 1'b0;
            phase = 0;
         end else if (!reset && $urandom_range(0, 1) == 0) begin
            reset = 1'b1;
         end
         @(negedge clk);
         check($sformatf("rnd%0d", c), model(phase, opcode, zero), phase);
         // Inputs changing mid-cycle must show without a clock edge.
         #1;
         opcode = opcode_t'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         #1 check($sformatf("rnd%0d_mid", c), model(phase, opcode, zero), phase);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces state to INST_ADDR immediately.
REQ-003 opcode  input  3  current instruction opcode, type opcode_t from package typedefs: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-004 zero  input  1  accumulator-is-zero flag.
REQ-005 mem_rd  output  1  memory read enable.
REQ-006 load_ir  output  1  instruction register load.
REQ-007 halt  output  1  halt request.
REQ-008 inc_pc  output  1  program counter increment.
REQ-009 load_ac  output  1  accumulator load.
REQ-010 load_pc  output  1  program counter load.
REQ-011 mem_wr  output  1  memory write enable.
REQ-012 Internal state register SHALL be named state, of enumerated type state_t from package typedefs, hierarchically visible, with enumeration names INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE (encodings 0..7 in that order).

Function
REQ-013 state SHALL advance one step per rising clk edge: INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE -> OP_ADDR -> OP_FETCH -> ALU_OP -> STORE -> INST_ADDR (8-cycle loop, unconditional wrap).
REQ-014 No state transition depends on opcode, zero or halt; halt is only an output, the sequence keeps cycling.
REQ-015 Outputs SHALL be purely combinational from state, opcode and zero (no output registers); opcode/zero changes reflect in the same cycle.
REQ-016 Define aluop = opcode in {ADD, AND, XOR, LDA}.
REQ-017 INST_ADDR: all outputs 0.
REQ-018 INST_FETCH: mem_rd=1; others 0.
REQ-019 INST_LOAD: mem_rd=1, load_ir=1; others 0.
REQ-020 IDLE: mem_rd=1, load_ir=1; others 0.
REQ-021 OP_ADDR: inc_pc=1, halt=(opcode==HLT); others 0.
REQ-022 OP_FETCH: mem_rd=aluop; others 0.
REQ-023 ALU_OP: mem_rd=aluop, load_ac=aluop, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP); others 0.
REQ-024 STORE: mem_rd=aluop, load_ac=aluop, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO); others 0.
REQ-025 Any unknown/out-of-range state value SHALL drive all outputs 0 and return to INST_ADDR on the next edge.
REQ-026 Outputs SHALL never be X/Z when inputs are known.

Reset
REQ-027 reset low SHALL asynchronously set state=INST_ADDR, hence all outputs 0, regardless of clk.
REQ-028 While reset is low state holds INST_ADDR; first rising edge after reset deasserts moves to INST_FETCH.
REQ-029 Reset asserted mid-sequence SHALL abort the cycle immediately; no partial outputs persist.

Verification
(vector = {mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr}, sampled on falling clk)
REQ-030 Reset pulse then release, opcode=HLT, zero=0 -> over 8 cycles: 0000000, 1000000, 1100000, 1100000, 0011000, 0000000, 0000000, 0000000.
REQ-031 opcode=ADD (also AND, XOR, LDA), zero=0 -> OP_ADDR 0001000, OP_FETCH 1000000, ALU_OP 1000100, STORE 1000100.
REQ-032 opcode=SKZ: zero=1 -> ALU_OP 0001000; zero=0 -> ALU_OP 0000000; STORE 0000000 both.
REQ-033 opcode=STO -> OP_FETCH 0000000, ALU_OP 0000000, STORE 0000001.
REQ-034 opcode=JMP -> ALU_OP 0000010, STORE 0001010.
REQ-035 Assert reset low while in ALU_OP with opcode=ADD -> outputs 0000000 immediately without clk edge; after release sequence restarts at INST_ADDR.
